// File: rtl/bus_transfer_ctrl_pkg.sv
// Shared constants for the bus transfer controller: mux source select codes,
// idle select code, default sizing and the controller state encoding.
package bus_transfer_ctrl_pkg;

   localparam int DEF_NUM_SRC = 24;
   localparam int DEF_NUM_DST = 24;
   localparam int DEF_SEL_W   = 5;
   localparam int DEF_CNT_W   = 16;

   // Unmapped mux code: the bus reads as zero while nobody drives it.
   localparam logic [4:0] IDLE_SEL = 5'd31;

   localparam logic [4:0] SRC_R0     = 5'd0;
   localparam logic [4:0] SRC_R1     = 5'd1;
   localparam logic [4:0] SRC_R2     = 5'd2;
   localparam logic [4:0] SRC_R3     = 5'd3;
   localparam logic [4:0] SRC_R4     = 5'd4;
   localparam logic [4:0] SRC_R5     = 5'd5;
   localparam logic [4:0] SRC_R6     = 5'd6;
   localparam logic [4:0] SRC_R7     = 5'd7;
   localparam logic [4:0] SRC_R8     = 5'd8;
   localparam logic [4:0] SRC_R9     = 5'd9;
   localparam logic [4:0] SRC_R10    = 5'd10;
   localparam logic [4:0] SRC_R11    = 5'd11;
   localparam logic [4:0] SRC_R12    = 5'd12;
   localparam logic [4:0] SRC_R13    = 5'd13;
   localparam logic [4:0] SRC_R14    = 5'd14;
   localparam logic [4:0] SRC_R15    = 5'd15;
   localparam logic [4:0] SRC_HI     = 5'd16;
   localparam logic [4:0] SRC_LO     = 5'd17;
   localparam logic [4:0] SRC_ZHI    = 5'd18;
   localparam logic [4:0] SRC_ZLO    = 5'd19;
   localparam logic [4:0] SRC_PC     = 5'd20;
   localparam logic [4:0] SRC_MDR    = 5'd21;
   localparam logic [4:0] SRC_INPORT = 5'd22;
   localparam logic [4:0] SRC_C      = 5'd23;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      LOAD  = 2'd2
   } state_e;

endpackage

// File: rtl/bus_transfer_ctrl_onehot_encoder_chk.sv
// One-hot to binary encoder; valid_o is high only when exactly one bit is set,
// so code_o is meaningful only while valid_o is high.
module onehot_encoder_chk #(
   parameter int N = 24,
   parameter int W = 5
) (
   input  logic [N-1:0] onehot_i,
   output logic [W-1:0] code_o,
   output logic         valid_o
);

   always_comb begin
      code_o = '0;
      for (int i = 0; i < N; i++) begin
         if (onehot_i[i]) code_o = code_o | W'(i);
      end
   end

   // Clearing the lowest set bit leaves zero only for a single-bit vector.
   assign valid_o = (onehot_i != '0) && ((onehot_i & (onehot_i - N'(1))) == '0);

endmodule

// File: rtl/bus_transfer_ctrl.sv
// Source-side bus transfer controller: encodes a one-hot source strobe into the
// mux select, holds it for a settle cycle, then pulses the destination load.
module bus_transfer_ctrl
   import bus_transfer_ctrl_pkg::*;
#(
   parameter int NUM_SRC = DEF_NUM_SRC,
   parameter int NUM_DST = DEF_NUM_DST,
   parameter int SEL_W   = DEF_SEL_W,
   parameter int CNT_W   = DEF_CNT_W
) (
   input  logic               clk,
   input  logic               clr_n,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [NUM_SRC-1:0] src_out,
   input  logic [SEL_W-1:0]   dst_code,
   output logic [SEL_W-1:0]   bus_sel,
   output logic               bus_busy,
   output logic [NUM_DST-1:0] dst_load,
   output logic               done,
   output logic               err,
   output logic               err_sticky,
   output logic [CNT_W-1:0]   xfer_count
);

   localparam logic [SEL_W-1:0] IDLE_CODE = SEL_W'(IDLE_SEL);

   state_e             state_q, state_d;
   logic [SEL_W-1:0]   sel_q, sel_d;
   logic [SEL_W-1:0]   dst_q, dst_d;
   logic [NUM_DST-1:0] load_q, load_d;
   logic               done_q, done_d;
   logic               err_q, err_d;
   logic               sticky_q, sticky_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic [SEL_W-1:0]   enc_code;
   logic               enc_valid;
   logic               dst_ok;

   onehot_encoder_chk #(
      .N (NUM_SRC),
      .W (SEL_W)
   ) u_enc (
      .onehot_i (src_out),
      .code_o   (enc_code),
      .valid_o  (enc_valid)
   );

   assign dst_ok = 32'(dst_code) < NUM_DST;

   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      dst_d    = dst_q;
      load_d   = '0;
      done_d   = 1'b0;
      err_d    = 1'b0;
      sticky_d = sticky_q;
      cnt_d    = cnt_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               if (enc_valid && dst_ok) begin
                  state_d = DRIVE;
                  sel_d   = enc_code;
                  dst_d   = dst_code;
               end else begin
                  err_d    = 1'b1;
                  sticky_d = 1'b1;
               end
            end
         end
         // Select has settled for a cycle; commit the load on the next one.
         DRIVE: begin
            state_d = LOAD;
            load_d  = NUM_DST'(1) << dst_q;
            done_d  = 1'b1;
            cnt_d   = cnt_q + CNT_W'(1);
         end
         LOAD: begin
            state_d = IDLE;
            sel_d   = IDLE_CODE;
         end
         default: begin
            state_d = IDLE;
            sel_d   = IDLE_CODE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!clr_n) begin
         state_q  <= IDLE;
         sel_q    <= IDLE_CODE;
         dst_q    <= '0;
         load_q   <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         sticky_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         dst_q    <= dst_d;
         load_q   <= load_d;
         done_q   <= done_d;
         err_q    <= err_d;
         sticky_q <= sticky_d;
         cnt_q    <= cnt_d;
      end
   end

   assign req_ready  = (state_q == IDLE);
   assign bus_busy   = (state_q != IDLE);
   assign bus_sel    = sel_q;
   assign dst_load   = load_q;
   assign done       = done_q;
   assign err        = err_q;
   assign err_sticky = sticky_q;
   assign xfer_count = cnt_q;

endmodule

// File: doc/bus_transfer_ctrl.md
Name: bus_transfer_ctrl

Overview:
- Drives the datapath bus from the source side. Accepts a transfer request as a one-hot set of source "out" strobes plus a destination code.
- Encodes the source into the 5-bit select code used by the 32-to-1 bus multiplexer. Holds that code stable for one settle cycle, then pulses a one-hot load enable to the destination register.
- Sits between the control unit and the bus multiplexer/register file.
- Rejects malformed requests and counts completed transfers.

Parameters:
- NUM_SRC, 24, number of bus sources; strobe index i corresponds to mux select code i (R0-R15=0-15, HI=16, LO=17, Zhigh=18, Zlow=19, PC=20, MDR=21, InPort=22, C=23).
- NUM_DST, 24, number of destination load enables.
- SEL_W, 5, select code width.
- IDLE_SEL, 31, select code driven when not transferring; an unmapped code, so the mux outputs zero.
- CNT_W, 16, transfer counter width.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- clr_n  in  1  synchronous active-low reset, sampled on the clk rising edge.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request; high only in IDLE.
- src_out  in  NUM_SRC  one-hot source strobes; sampled only at acceptance.
- dst_code  in  SEL_W  destination index; sampled only at acceptance.
- bus_sel  out  SEL_W  registered select code to the bus mux.
- bus_busy  out  1  high while the bus is owned (DRIVE and LOAD).
- dst_load  out  NUM_DST  one-hot, single-cycle destination load enable.
- done  out  1  single-cycle pulse on successful completion.
- err  out  1  single-cycle pulse on a rejected request.
- err_sticky  out  1  set by any err pulse; cleared only by reset.
- xfer_count  out  CNT_W  number of successful transfers; wraps.

Behaviour:
- Reset: clr_n low at a clk edge puts the block in IDLE on the next cycle, with:
  - bus_sel=IDLE_SEL; bus_busy=0; dst_load=0; done=0; err=0; err_sticky=0; xfer_count=0.
  - req_ready=1 from the first cycle after reset.
- States: IDLE, DRIVE, LOAD. All outputs are registered or decoded from state only; there are no combinational paths from inputs to outputs.
- Acceptance: a request is accepted in any cycle where the state is IDLE and req_valid=1. req_ready equals (state==IDLE).
- Valid request (exactly one bit of src_out set, and dst_code < NUM_DST):
  - Cycle N: accepted.
  - N+1: DRIVE. bus_sel = index of the set bit; bus_busy=1.
  - N+2: LOAD. bus_sel is held; bus_busy=1; dst_load[dst_code]=1; done=1; xfer_count increments by 1.
  - N+3: IDLE. bus_sel=IDLE_SEL; req_ready=1.
- Throughput: one transfer per 3 cycles. A request held across completion is re-accepted at N+3.
- Invalid request (src_out zero, src_out with two or more bits set, or dst_code >= NUM_DST):
  - Cycle N: accepted.
  - N+1: err=1; err_sticky=1; state stays IDLE; bus_sel stays IDLE_SEL; no dst_load; xfer_count unchanged.
  - No priority resolution is applied to multi-hot sources.
- dst_load is never multi-hot and is never asserted outside LOAD.
- xfer_count wraps from 2^CNT_W-1 to 0 without any flag.
- src_out and dst_code changes after acceptance have no effect. Both are captured into internal registers at acceptance.
- Reset in DRIVE or LOAD:
  - The next cycle is IDLE with all outputs at reset values.
  - No dst_load or done is issued for the aborted transfer, and it is not counted.
  - Reset in the same cycle as req_valid: reset wins and the request is not accepted.
- req_valid=1 in DRIVE or LOAD: ignored. req_ready=0 signals this to the requester.

Decomposition:
- Shared package holds:
  - The source index constants (SRC_R0..SRC_R15, SRC_HI, SRC_LO, SRC_ZHI, SRC_ZLO, SRC_PC, SRC_MDR, SRC_INPORT, SRC_C).
  - IDLE_SEL.
  - The state encoding (IDLE=2'd0, DRIVE=2'd1, LOAD=2'd2).
- These source constants must match the bus mux select codes.
- One natural sub-module, onehot_encoder_chk: combinational NUM_SRC one-hot to SEL_W encoder with a valid flag, where valid means exactly one bit is set.

Test Plan:
- Reset then idle: after clr_n low for 2 cycles and released -> bus_sel=31, req_ready=1, err_sticky=0, xfer_count=0.
- Valid transfer: src_out=1<<20 (PC), dst_code=5 at cycle N -> bus_sel=20 at N+1 and N+2; dst_load=1<<5 and done=1 at N+2 only; xfer_count=1; bus_sel=31 at N+3.
- Rejects: each of the following -> err pulse at N+1 only, err_sticky=1, no dst_load, xfer_count unchanged, bus_sel=31:
  - src_out=0x000003 (multi-hot).
  - src_out=0.
  - src_out=1<<3 with dst_code=30 (out-of-range destination).
- Back-to-back: req_valid held high with src 17 then 21 -> acceptances 3 cycles apart; bus_sel sequence 17,17,31,21,21; two done pulses; xfer_count=2.
- Abort: clr_n low during DRIVE of a src 9 transfer -> no dst_load, no done, xfer_count unchanged, req_ready=1 the cycle after reset releases.
- Wrap: run 65536 valid transfers -> xfer_count returns to 0; dst_load stays one-hot throughout (checked by assertion).
